veopixels_decoder: RTL

VEOPIXELS_DECODER -- requirements
Module: veopixels_decoder

---
 rtl/veopixels_pkg.sv | 24 ++
 rtl/veopixels_di_sync.sv | 22 ++
 rtl/veopixels_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/veopixels_pkg.sv
// Shared types, default timing and helpers for the pixel-line decoder.
// Timing defaults assume a 50 MHz clk_sys and a 1220 ns bit cell (61 clk).
package veopixels_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int CLK_HZ               = 50_000_000;
   localparam int BIT_CLKS             = 61;
   localparam int DEF_LENGTH           = 4;
   localparam int DEF_T1_THRESH        = 30;
   localparam int DEF_MIN_HIGH         = 5;
   localparam int DEF_MAX_HIGH         = 55;
   localparam int DEF_RESET_CYCLES     = 2500;

   // Wire order is G,R,B; downstream logic wants R,G,B.
   function automatic logic [23:0] grb_to_rgb(input logic [23:0] grb);
      return {grb[15:8], grb[23:16], grb[7:0]};
   endfunction

endpackage

// File: rtl/veopixels_di_sync.sv
// Two-flop synchronizer bringing the asynchronous pixel line into clk.
module veopixels_di_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta;

   // Shift the raw line through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/veopixels_decoder.sv
// Serial pixel-line decoder: measures high pulse widths, assembles 24-bit
// GRB words, strobes {R,G,B} pixels and detects the latch gap.
// Optional macro VEOPIXELS_FORWARD_EN forwards pixels beyond LENGTH on DO.
//
// state | meaning
// IDLE  | line quiet after latch gap or reset, waiting for first rise
// HIGH  | line high, measuring the pulse width
// LOW   | line low between bits, watching for the latch gap
module veopixels_decoder
   import veopixels_pkg::*;
#(
   parameter int LENGTH       = DEF_LENGTH,
   parameter int T1_THRESH    = DEF_T1_THRESH,
   parameter int MIN_HIGH     = DEF_MIN_HIGH,
   parameter int MAX_HIGH     = DEF_MAX_HIGH,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   localparam int IW          = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          DI,
   output logic [23:0]   pixel_rgb,
   output logic [IW-1:0] pixel_index,
   output logic          pixel_valid,
   output logic          frame_done,
   output logic          error,
   output logic          overflow,
   output logic          DO
);

   localparam int HW = $clog2(MAX_HIGH + 2);
   localparam int LW = $clog2(RESET_CYCLES + 1);
   localparam int PW = $clog2(LENGTH + 1);
   localparam logic [HW-1:0] H_SAT = HW'(MAX_HIGH + 1);

   logic          di_s;
   state_t        state, state_nxt;
   logic          rise, fall, latch;
   logic [HW-1:0] hcnt;
   logic [LW-1:0] lcnt;
   logic [22:0]   sr;
   logic [4:0]    bcnt;
   logic [PW-1:0] pcnt;
   logic          glitch, too_long, bit_val, good_bit, complete;
   logic [23:0]   word;

   veopixels_di_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (DI),
      .dout (di_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus rise/fall/latch events derived from the line.
   always_comb begin
      state_nxt = state;
      rise      = 1'b0;
      fall      = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: if (di_s) begin
            state_nxt = HIGH;
            rise      = 1'b1;
         end
         HIGH: if (!di_s) begin
            state_nxt = LOW;
            fall      = 1'b1;
         end
         LOW: begin
            if (di_s) begin
               state_nxt = HIGH;
               rise      = 1'b1;
            end else if (lcnt >= LW'(RESET_CYCLES - 1)) begin
               state_nxt = IDLE;
               latch     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pulse classification on the falling edge.
   always_comb begin
      glitch   = (hcnt < HW'(MIN_HIGH));
      too_long = (hcnt > HW'(MAX_HIGH));
      bit_val  = (hcnt >= HW'(T1_THRESH));
      good_bit = fall && !glitch && !too_long;
      word     = {sr, bit_val};
      complete = good_bit && (bcnt == 5'd23);
   end

   // Saturating high/low width counters; the fall cycle is the first low cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         lcnt <= '0;
      end else begin
         if (rise)
            hcnt <= HW'(1);
         else if (state == HIGH && di_s && hcnt != H_SAT)
            hcnt <= hcnt + HW'(1);
         if (fall)
            lcnt <= LW'(1);
         else if (state == LOW && !di_s && lcnt != LW'(RESET_CYCLES))
            lcnt <= lcnt + LW'(1);
      end
   end

   // Bit assembly, pixel strobes, frame latch and error reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr          <= '0;
         bcnt        <= '0;
         pcnt        <= '0;
         pixel_rgb   <= '0;
         pixel_index <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         error       <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         error       <= 1'b0;
         if (fall && too_long) begin
            error <= 1'b1;
            bcnt  <= '0;
         end else if (complete) begin
            bcnt <= '0;
            if (pcnt < PW'(LENGTH)) begin
               pixel_valid <= 1'b1;
               pixel_rgb   <= grb_to_rgb(word);
               pixel_index <= pcnt[IW-1:0];
               pcnt        <= pcnt + PW'(1);
            end else begin
               overflow <= 1'b1;
            end
         end else if (good_bit) begin
            sr   <= {sr[21:0], bit_val};
            bcnt <= bcnt + 5'd1;
         end else if (latch) begin
            frame_done <= 1'b1;
            error      <= (bcnt != 5'd0);
            pcnt       <= '0;
            bcnt       <= '0;
            overflow   <= 1'b0;
         end
      end
   end

`ifdef VEOPIXELS_FORWARD_EN
   logic fwd_en;

   // Forward gate opens/closes only while the line is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fwd_en <= 1'b0;
      else if (latch)
         fwd_en <= 1'b0;
      else if (!di_s && pcnt >= PW'(LENGTH))
         fwd_en <= 1'b1;
   end

   assign DO = fwd_en & di_s;
`else
   assign DO = 1'b0;
`endif

endmodule
